// File: rtl/router_pkg.sv
// Shared Router 1x3 definitions: header field positions, sync timeout
// and the destination-reader state encoding.
package router_pkg;

    localparam int HDR_LEN_MSB        = 7;
    localparam int HDR_LEN_LSB        = 2;
    localparam int HDR_ADDR_MSB       = 1;
    localparam int HDR_ADDR_LSB       = 0;
    localparam int SOFT_RESET_TIMEOUT = 30;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        HDR   = 3'd2,
        HCAP  = 3'd3,
        BODY  = 3'd4,
        DRAIN = 3'd5
    } rx_state_t;

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR register for packet parity.
// Ports: clock/reset, clear (zero), load (set to din), acc (xor din), parity.
module router_parity_acc (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic       acc,
    input  logic [7:0] din,
    output logic [7:0] parity
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            parity <= 8'h00;
        else if (clear)
            parity <= 8'h00;
        else if (load)
            parity <= din;
        else if (acc)
            parity <= parity ^ din;
    end

endmodule

// File: rtl/router_dest_rx.sv
// Destination-side packet reader for one router output port.
// Ports: clock/reset; vld_out, soft_reset, data_out, stall in;
// read_enb, busy, pkt_done, pkt_abort, pkt_len, parity_err, addr_err, pkt_cnt out.
module router_dest_rx
    import router_pkg::*;
#(
    parameter logic [1:0] PORT_ID     = 2'b00,
    parameter int         START_DELAY = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       vld_out,
    input  logic       soft_reset,
    input  logic [7:0] data_out,
    input  logic       stall,
    output logic       read_enb,
    output logic       busy,
    output logic       pkt_done,
    output logic       pkt_abort,
    output logic [5:0] pkt_len,
    output logic       parity_err,
    output logic       addr_err,
    output logic [7:0] pkt_cnt
);

    localparam logic [5:0] WAIT_LAST =
        (START_DELAY > 0) ? 6'(START_DELAY - 1) : 6'd0;

    rx_state_t  state;
    logic       rd_pend;
    logic [6:0] remaining;
    logic [5:0] hdr_len;
    logic [1:0] hdr_addr;
    logic [5:0] wait_cnt;
    logic [7:0] acc_val;
    logic       abort;
    logic       par_bad;
    logic       addr_bad;

    assign abort    = soft_reset && (state != IDLE);
    assign par_bad  = (acc_val != data_out);
    assign addr_bad = (hdr_addr != PORT_ID);

    always_comb begin
        read_enb = 1'b0;
        if (state == HDR)
            read_enb = 1'b1;
        else if (state == BODY)
            read_enb = vld_out && !stall && (remaining != 7'd0);
        busy = (state != IDLE);
    end

    // Header loads the accumulator; only payload captures in BODY fold in.
    // The parity byte itself is captured in DRAIN and compared, never folded.
    router_parity_acc u_par (
        .clock  (clock),
        .reset  (reset),
        .clear  (abort),
        .load   (state == HCAP),
        .acc    ((state == BODY) && rd_pend),
        .din    (data_out),
        .parity (acc_val)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rd_pend    <= 1'b0;
            remaining  <= 7'd0;
            hdr_len    <= 6'd0;
            hdr_addr   <= 2'd0;
            wait_cnt   <= 6'd0;
            pkt_done   <= 1'b0;
            pkt_abort  <= 1'b0;
            pkt_len    <= 6'd0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            pkt_cnt    <= 8'd0;
        end else begin
            pkt_done  <= 1'b0;
            pkt_abort <= 1'b0;
            rd_pend   <= read_enb;
            if (abort) begin
                // Flush wins over everything; the in-flight byte is dropped.
                state     <= IDLE;
                pkt_abort <= 1'b1;
                rd_pend   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (vld_out) begin
                            wait_cnt <= 6'd0;
                            state    <= (START_DELAY == 0) ? HDR : WAIT;
                        end
                    end
                    WAIT: begin
                        if (wait_cnt == WAIT_LAST)
                            state <= HDR;
                        else
                            wait_cnt <= wait_cnt + 6'd1;
                    end
                    HDR: state <= HCAP;
                    HCAP: begin
                        hdr_len   <= data_out[HDR_LEN_MSB:HDR_LEN_LSB];
                        hdr_addr  <= data_out[HDR_ADDR_MSB:HDR_ADDR_LSB];
                        // Payload bytes plus the trailing parity byte.
                        remaining <= {1'b0, data_out[HDR_LEN_MSB:HDR_LEN_LSB]}
                                     + 7'd1;
                        state     <= BODY;
                    end
                    BODY: begin
                        if (read_enb) begin
                            remaining <= remaining - 7'd1;
                            if (remaining == 7'd1)
                                state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        pkt_done   <= 1'b1;
                        pkt_len    <= hdr_len;
                        parity_err <= par_bad;
                        addr_err   <= addr_bad;
                        if (!par_bad && !addr_bad)
                            pkt_cnt <= pkt_cnt + 8'd1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_router_dest_rx.sv
// Directed bench for router_dest_rx: FIFO model for the main port and
// a timeout model driving soft_reset on a long-start-delay instance.
module tb_router_dest_rx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       vld_out;
    logic       soft_reset = 1'b0;
    logic [7:0] data_out = 8'h00;
    logic       stall = 1'b0;
    logic       read_enb, busy, pkt_done, pkt_abort;
    logic [5:0] pkt_len;
    logic       parity_err, addr_err;
    logic [7:0] pkt_cnt;

    logic       vld_d = 1'b0;
    logic       soft_d = 1'b0;
    logic [7:0] data_d = 8'h00;
    logic       stall_d = 1'b0;
    logic       read_enb_d, busy_d, pkt_done_d, pkt_abort_d;
    logic [5:0] pkt_len_d;
    logic       parity_err_d, addr_err_d;
    logic [7:0] pkt_cnt_d;

    logic [7:0] mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    logic       vld_block = 1'b0;
    int         rd_total = 0;
    int         rd_total_d = 0;
    int         tmo = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    assign vld_out = !vld_block && (wr_ptr != rd_ptr);

    router_dest_rx #(.PORT_ID(2'b00), .START_DELAY(0)) dut (
        .clock(clock), .reset(reset), .vld_out(vld_out),
        .soft_reset(soft_reset), .data_out(data_out), .stall(stall),
        .read_enb(read_enb), .busy(busy), .pkt_done(pkt_done),
        .pkt_abort(pkt_abort), .pkt_len(pkt_len),
        .parity_err(parity_err), .addr_err(addr_err), .pkt_cnt(pkt_cnt)
    );

    router_dest_rx #(.PORT_ID(2'b00), .START_DELAY(40)) dut_d (
        .clock(clock), .reset(reset), .vld_out(vld_d),
        .soft_reset(soft_d), .data_out(data_d), .stall(stall_d),
        .read_enb(read_enb_d), .busy(busy_d), .pkt_done(pkt_done_d),
        .pkt_abort(pkt_abort_d), .pkt_len(pkt_len_d),
        .parity_err(parity_err_d), .addr_err(addr_err_d),
        .pkt_cnt(pkt_cnt_d)
    );

    // FIFO model: a read sampled at edge k presents its byte until edge k+1.
    always @(posedge clock) begin
        if (read_enb) begin
            rd_total <= rd_total + 1;
            if (wr_ptr != rd_ptr) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 8'd1;
            end
        end
        if (read_enb_d)
            rd_total_d <= rd_total_d + 1;
    end

    // Sync timeout model: 30 cycles of valid data without a read.
    always @(posedge clock) begin
        if (vld_d && !read_enb_d) begin
            if (tmo == 29) begin
                soft_d <= 1'b1;
                tmo    <= 0;
            end else begin
                soft_d <= 1'b0;
                tmo    <= tmo + 1;
            end
        end else begin
            soft_d <= 1'b0;
            tmo    <= 0;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    task automatic wait_end(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (pkt_done || pkt_abort) seen = 1'b1;
        end
    endtask

    task automatic wait_reads(input int base, input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clock);
            if (rd_total - base >= n) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [24:0] outs;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        outs = {read_enb, busy, pkt_done, pkt_abort, pkt_len,
                parity_err, addr_err, pkt_cnt};
        checks++;
        if (outs !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
        reset = 1'b0;
        @(negedge clock);
        soft_reset = 1'b1;
        @(negedge clock);
        soft_reset = 1'b0;
        checks++;
        if ({pkt_abort, busy} !== 2'b00) begin
            errors++;
            $display("FAIL idle_soft_reset got %b want 00", {pkt_abort, busy});
        end
    endtask

    task automatic test_basic();
        logic [8:0] exp_rd = 9'b000111101;
        logic [8:0] exp_dn = 9'b010000000;
        int base = rd_total;
        push(8'h0C); push(8'h11); push(8'h22); push(8'h33); push(8'h0C);
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            checks++;
            if (read_enb !== exp_rd[i]) begin
                errors++;
                $display("FAIL basic_read_enb[%0d] got %b want %b",
                         i, read_enb, exp_rd[i]);
            end
            checks++;
            if (pkt_done !== exp_dn[i]) begin
                errors++;
                $display("FAIL basic_pkt_done[%0d] got %b want %b",
                         i, pkt_done, exp_dn[i]);
            end
        end
        checks++;
        if (rd_total - base !== 5) begin
            errors++;
            $display("FAIL basic_reads got %0d want 5", rd_total - base);
        end
        checks++;
        if ({pkt_len, parity_err, addr_err, pkt_cnt, busy}
            !== {6'd3, 1'b0, 1'b0, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL basic_result got len %0d perr %b aerr %b cnt %0d busy %b want 3 0 0 1 0",
                     pkt_len, parity_err, addr_err, pkt_cnt, busy);
        end
    endtask

    task automatic test_parity_err();
        bit seen;
        push(8'h0C); push(8'h11); push(8'h22); push(8'h33); push(8'h00);
        wait_end(seen);
        checks++;
        if (!seen || !pkt_done) begin
            errors++;
            $display("FAIL parity_done got %b want 1", seen);
        end
        @(negedge clock);
        checks++;
        if ({parity_err, addr_err, pkt_len, pkt_cnt}
            !== {1'b1, 1'b0, 6'd3, 8'd1}) begin
            errors++;
            $display("FAIL parity_result got perr %b aerr %b len %0d cnt %0d want 1 0 3 1",
                     parity_err, addr_err, pkt_len, pkt_cnt);
        end
    endtask

    task automatic test_addr_err();
        bit seen;
        int base = rd_total;
        push(8'h01); push(8'h01);
        wait_end(seen);
        @(negedge clock);
        checks++;
        if (!seen || rd_total - base !== 2) begin
            errors++;
            $display("FAIL addr_reads got seen %b reads %0d want 1 2",
                     seen, rd_total - base);
        end
        checks++;
        if ({addr_err, parity_err, pkt_len, pkt_cnt}
            !== {1'b1, 1'b0, 6'd0, 8'd1}) begin
            errors++;
            $display("FAIL addr_result got aerr %b perr %b len %0d cnt %0d want 1 0 0 1",
                     addr_err, parity_err, pkt_len, pkt_cnt);
        end
    endtask

    task automatic test_stall_vld();
        bit ok;
        bit seen;
        int base = rd_total;
        push(8'h14); push(8'h01); push(8'h02); push(8'h03);
        push(8'h04); push(8'h05); push(8'h15);
        wait_reads(base, 3, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_start got timeout want 3 reads");
        end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({read_enb, busy} !== 2'b01) begin
                errors++;
                $display("FAIL stall_hold[%0d] got %b want 01",
                         i, {read_enb, busy});
            end
            @(negedge clock);
        end
        stall = 1'b0;
        vld_block = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (read_enb !== 1'b0) begin
                errors++;
                $display("FAIL vld_hold[%0d] got %b want 0", i, read_enb);
            end
            @(negedge clock);
        end
        vld_block = 1'b0;
        wait_end(seen);
        @(negedge clock);
        checks++;
        if (!seen || rd_total - base !== 7) begin
            errors++;
            $display("FAIL stall_reads got seen %b reads %0d want 1 7",
                     seen, rd_total - base);
        end
        checks++;
        if ({pkt_len, parity_err, addr_err, pkt_cnt}
            !== {6'd5, 1'b0, 1'b0, 8'd2}) begin
            errors++;
            $display("FAIL stall_result got len %0d perr %b aerr %b cnt %0d want 5 0 0 2",
                     pkt_len, parity_err, addr_err, pkt_cnt);
        end
    endtask

    task automatic test_soft_abort();
        bit ok;
        int base = rd_total;
        push(8'h14); push(8'h01); push(8'h02); push(8'h03);
        push(8'h04); push(8'h05); push(8'h15);
        wait_reads(base, 3, ok);
        soft_reset = 1'b1;
        @(negedge clock);
        soft_reset = 1'b0;
        flush();
        checks++;
        if ({pkt_abort, busy, read_enb, pkt_done} !== 4'b1000) begin
            errors++;
            $display("FAIL abort_pulse got %b want 1000",
                     {pkt_abort, busy, read_enb, pkt_done});
        end
        @(negedge clock);
        checks++;
        if ({pkt_abort, busy, pkt_len, parity_err, pkt_cnt}
            !== {1'b0, 1'b0, 6'd5, 1'b0, 8'd2}) begin
            errors++;
            $display("FAIL abort_hold got abort %b busy %b len %0d perr %b cnt %0d want 0 0 5 0 2",
                     pkt_abort, busy, pkt_len, parity_err, pkt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_dn = 12'b001000010000;
        push(8'h00); push(8'h00); push(8'h00); push(8'h00);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            checks++;
            if (pkt_done !== exp_dn[i]) begin
                errors++;
                $display("FAIL b2b_pkt_done[%0d] got %b want %b",
                         i, pkt_done, exp_dn[i]);
            end
        end
        checks++;
        if (pkt_cnt !== 8'd4) begin
            errors++;
            $display("FAIL b2b_cnt got %0d want 4", pkt_cnt);
        end
    endtask

    task automatic test_reset_mid_body();
        bit ok;
        bit seen;
        logic [24:0] outs;
        int base = rd_total;
        push(8'h0C); push(8'h11); push(8'h22); push(8'h33); push(8'h0C);
        wait_reads(base, 2, ok);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        outs = {read_enb, busy, pkt_done, pkt_abort, pkt_len,
                parity_err, addr_err, pkt_cnt};
        checks++;
        if (outs !== 25'd0) begin
            errors++;
            $display("FAIL async_reset got %h want 0", outs);
        end
        @(negedge clock);
        reset = 1'b0;
        flush();
        @(negedge clock);
        push(8'h0C); push(8'h11); push(8'h22); push(8'h33); push(8'h0C);
        wait_end(seen);
        @(negedge clock);
        checks++;
        if (!seen || {pkt_len, parity_err, addr_err, pkt_cnt}
            !== {6'd3, 1'b0, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL post_reset got seen %b len %0d perr %b aerr %b cnt %0d want 1 3 0 0 1",
                     seen, pkt_len, parity_err, addr_err, pkt_cnt);
        end
    endtask

    task automatic test_start_delay();
        int abort_at = -1;
        int aborts = 0;
        int base = rd_total_d;
        vld_d = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (i == 10) begin
                checks++;
                if (busy_d !== 1'b1) begin
                    errors++;
                    $display("FAIL delay_busy got %b want 1", busy_d);
                end
            end
            if (pkt_abort_d) begin
                aborts++;
                if (abort_at < 0) abort_at = i;
                vld_d = 1'b0;
            end
        end
        checks++;
        if (abort_at !== 30 || aborts !== 1) begin
            errors++;
            $display("FAIL delay_abort got at %0d count %0d want 30 1",
                     abort_at, aborts);
        end
        checks++;
        if (rd_total_d - base !== 0) begin
            errors++;
            $display("FAIL delay_reads got %0d want 0", rd_total_d - base);
        end
        checks++;
        if ({busy_d, pkt_done_d, pkt_len_d, pkt_cnt_d, parity_err_d,
             addr_err_d} !== 18'd0) begin
            errors++;
            $display("FAIL delay_state got busy %b cnt %0d len %0d want 0 0 0",
                     busy_d, pkt_cnt_d, pkt_len_d);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        @(negedge clock);
        test_parity_err();
        @(negedge clock);
        test_addr_err();
        @(negedge clock);
        test_stall_vld();
        @(negedge clock);
        test_soft_abort();
        @(negedge clock);
        test_back_to_back();
        @(negedge clock);
        test_reset_mid_body();
        @(negedge clock);
        test_start_delay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_dest_rx.md
# router_dest_rx

Destination-side packet reader for one Router 1x3 output port: the consumer at the far end of the FIFO/sync path. It watches the port's `vld_out`, drives `read_enb` into that port's FIFO, reassembles header/payload/parity, and checks address and parity. It answers the sync block's 30-cycle read timeout, and stops the packet cleanly when that block issues `soft_reset`. One instance per output port, in the top-level testbench environment and in the synthesizable loopback harness.

## Interface
Parameters:
- `PORT_ID`, 2'b00: expected address field for this port.
- `START_DELAY`, 0: idle cycles inserted after `vld_out` is first seen, before the header read (0..63).

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; all state and outputs cleared immediately.
- `vld_out`  in  1  port FIFO non-empty (from router_sync).
- `soft_reset`  in  1  timeout flush for this port (from router_sync).
- `data_out`  in  8  FIFO read data; valid the cycle after a sampled `read_enb`.
- `stall`  in  1  back-pressure; suppresses new reads while high.
- `read_enb`  out  1  FIFO read request.
- `busy`  out  1  high in every state except IDLE.
- `pkt_done`  out  1  one-cycle pulse when the parity byte is captured.
- `pkt_abort`  out  1  one-cycle pulse when a packet is dropped on `soft_reset`.
- `pkt_len`  out  6  payload length of the last completed packet.
- `parity_err`  out  1  last completed packet had bad parity; held until the next `pkt_done`.
- `addr_err`  out  1  last header address differed from `PORT_ID`; held until the next `pkt_done`.
- `pkt_cnt`  out  8  count of completed packets with no errors; wraps at 255 to 0.

## Operation
- Packet format: header byte = {len[5:0], addr[1:0]}; then len payload bytes; then one parity byte = XOR of the header byte and all payload bytes. len = 0 is legal and means the parity byte follows the header directly.
- FIFO read latency is fixed: a `read_enb` sampled at edge k presents its byte on `data_out` from edge k to edge k+1. The byte is captured at edge k+1. A registered `rd_pend` tracks each outstanding capture.
- `read_enb` is a combinational decode of registered state: it is asserted only in HDR, and in BODY when `vld_out` = 1, `stall` = 0 and `remaining` != 0.
- FSM states and transitions:
  - IDLE: go to WAIT when `vld_out` is sampled high. If START_DELAY = 0, go straight to HDR.
  - WAIT: count START_DELAY cycles, then go to HDR.
  - HDR: `read_enb` = 1 for exactly one cycle, then go to HCAP.
  - HCAP: capture the header, set `remaining` = len + 1, set the running XOR to the header byte, then go to BODY.
  - BODY: each sampled read decrements `remaining`. Each payload capture XORs into the parity accumulator. When `remaining` reaches 0, go to DRAIN.
  - DRAIN: capture the parity byte. On that same edge: pulse `pkt_done`, update `pkt_len`, `parity_err` (accumulator != byte) and `addr_err`; increment `pkt_cnt` only if both error flags are 0. Return to IDLE.
- `vld_out` falling or `stall` rising mid-BODY: pause reads and keep state. Captures already pending still complete.
- `soft_reset` sampled high in any state other than IDLE: go to IDLE, pulse `pkt_abort`, drop the pending capture, leave `pkt_len`, the error flags and `pkt_cnt` unchanged. In IDLE, `soft_reset` is ignored.
- `soft_reset` takes priority over every other transition on the same edge.

## Timing
- Reset values: IDLE; `read_enb` 0, `busy` 0, `pkt_done` 0, `pkt_abort` 0, `pkt_len` 0, `parity_err` 0, `addr_err` 0, `pkt_cnt` 0.
- With START_DELAY = 0, no stall and `vld_out` held high, for `vld_out` first sampled at edge 0:
  - Header read is high in cycle 0→1; header captured at edge 2 (one bubble cycle).
  - Body reads are high in cycles 2→(N+3).
  - `pkt_done` is high in cycle (N+4)→(N+5).
- Minimum packet-to-packet spacing is one IDLE cycle after DRAIN.
- A START_DELAY ≥ 30 guarantees a router_sync timeout, so `pkt_abort` pulses.

## Structure
- Shared `router_pkg`: `HDR_LEN_MSB`/`LSB`, `HDR_ADDR_MSB`/`LSB`, `SOFT_RESET_TIMEOUT` = 30, and the state enum `rx_state_t` {IDLE, WAIT, HDR, HCAP, BODY, DRAIN}.
- One natural sub-module: `router_parity_acc` (clear/load/accumulate XOR register), also reused by the source-side generator.

## Test plan
- Reset mid-BODY (assert `reset` asynchronously between edges) → all outputs 0 immediately, without waiting for an edge; the next packet is received normally.
- addr 00, len 3, payload 0x11/0x22/0x33, correct parity → `read_enb` high for 5 cycles total; `pkt_done` pulses once; `pkt_len` = 3; `parity_err` = 0, `addr_err` = 0; `pkt_cnt` = 1.
- Same packet with the parity byte flipped to 0x00 → `parity_err` = 1; `pkt_cnt` unchanged.
- Header address 01 while `PORT_ID` = 00, len 0 → 2 reads; `addr_err` = 1; `pkt_len` = 0.
- len 5 with `stall` high for 4 cycles after the 2nd payload read, and `vld_out` dropping for 3 cycles → no reads while either condition holds; all 7 bytes are still captured in order, and the result has correct parity.
- START_DELAY = 40 with router_sync in the loop → `soft_reset` fires at cycle 30 while in WAIT; `pkt_abort` pulses; no `read_enb` is issued; FSM returns to IDLE; counters unchanged.
